// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: default tag width, source
// indices and the packed {value, tag} entry width.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_ROB_WIDTH = 4;
  localparam int unsigned CDB_NUM_SRC   = 3;

  // Source indices on the CDB (cdb_src encoding).
  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_BR   = 2;

  localparam int unsigned CDB_ENTRY_W = 32 + CDB_ROB_WIDTH;

  // Width of one queued result: 32-bit value above a ROB tag.
  function automatic int unsigned cdb_entry_w(input int unsigned rob_width);
    return 32 + rob_width;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Single-source result FIFO. Count is kept separately from the pointers so
// full and empty are distinct; flush empties the queue in one cycle.
module cdb_src_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  // Next pointers and occupancy; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only slots below count are ever read out.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs drained round-robin, one head per
// cycle, onto a registered broadcast feeding the ROB and reservation stations.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned ROB_WIDTH  = CDB_ROB_WIDTH,
  parameter int unsigned NUM_SRC    = CDB_NUM_SRC,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SrcW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_signal,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*32-1:0]      src_value,
  input  logic [NUM_SRC*ROB_WIDTH-1:0] src_tag,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       cdb_valid,
  output logic [31:0]                cdb_value,
  output logic [ROB_WIDTH-1:0]       cdb_tag,
  output logic [SrcW-1:0]            cdb_src
);

  localparam int unsigned EntryW = cdb_entry_w(ROB_WIDTH);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [NUM_SRC-1:0] push, pop, nonempty;
  logic [EntryW-1:0]  head [NUM_SRC];
  logic [CntW-1:0]    count [NUM_SRC];
  logic               flush;

  logic               grant_valid;
  logic [SrcW-1:0]    grant_idx, rr_next, rr_ptr_q;
  logic [EntryW-1:0]  grant_entry;

  logic               cdb_valid_q;
  logic [31:0]        cdb_value_q;
  logic [ROB_WIDTH-1:0] cdb_tag_q;
  logic [SrcW-1:0]    cdb_src_q;

  assign flush = rdy_in & clear_signal;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Ready depends only on registered occupancy, so a full FIFO never
    // accepts, even when it is being popped in the same cycle.
    assign src_ready[i] = count[i] < DepthCnt;
    assign nonempty[i]  = count[i] != '0;
    assign push[i]      = rdy_in & ~clear_signal & src_valid[i] & src_ready[i];

    cdb_src_fifo #(
      .Width(EntryW),
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk_in),
      .rst_ni (rst_in),
      .flush_i(flush),
      .push_i (push[i]),
      .pop_i  (pop[i]),
      .data_i ({src_value[32*i +: 32], src_tag[ROB_WIDTH*i +: ROB_WIDTH]}),
      .head_o (head[i]),
      .count_o(count[i])
    );
  end

  // Round-robin scan: first non-empty source starting at rr_ptr.
  always_comb begin
    logic [SrcW-1:0] idx;
    idx         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = SrcW'((32'(rr_ptr_q) + k) % NUM_SRC);
      if (!grant_valid && nonempty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant_entry = head[idx];
      end
    end
    rr_next = (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + SrcW'(1);
  end

  // Pop the granted head only on an active, non-flush cycle.
  always_comb begin
    pop = '0;
    if (rdy_in && !clear_signal && grant_valid) pop[grant_idx] = 1'b1;
  end

  // Registered broadcast and round-robin pointer; everything holds while paused.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        cdb_valid_q <= 1'b0;
        rr_ptr_q    <= '0;
      end else if (grant_valid) begin
        cdb_valid_q <= 1'b1;
        cdb_value_q <= grant_entry[EntryW-1 -: 32];
        cdb_tag_q   <= grant_entry[ROB_WIDTH-1:0];
        cdb_src_q   <= grant_idx;
        rr_ptr_q    <= rr_next;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_value = cdb_value_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts in
// hand-derived order; a negedge monitor pops and compares each consumed one.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned RW = 4;
  localparam int unsigned NS = 3;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              rdy_in = 1'b1;
  logic              clear_signal = 1'b0;
  logic [NS-1:0]     src_valid;
  logic [NS*32-1:0]  src_value;
  logic [NS*RW-1:0]  src_tag;
  logic [NS-1:0]     src_ready;
  logic              cdb_valid;
  logic [31:0]       cdb_value;
  logic [RW-1:0]     cdb_tag;
  logic [1:0]        cdb_src;

  typedef struct packed {
    logic [31:0]   value;
    logic [RW-1:0] tag;
    logic [1:0]    src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  cdb_arbiter #(
    .ROB_WIDTH (RW),
    .NUM_SRC   (NS),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear_signal(clear_signal),
    .src_valid   (src_valid),
    .src_value   (src_value),
    .src_tag     (src_tag),
    .src_ready   (src_ready),
    .cdb_valid   (cdb_valid),
    .cdb_value   (cdb_value),
    .cdb_tag     (cdb_tag),
    .cdb_src     (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_src(input int i, input logic [31:0] v, input logic [RW-1:0] t);
    src_valid[i]          = 1'b1;
    src_value[32*i +: 32] = v;
    src_tag[RW*i +: RW]   = t;
  endtask

  task automatic expect_bc(input logic [31:0] v, input logic [RW-1:0] t, input logic [1:0] s);
    exp_t e;
    e.value = v;
    e.tag   = t;
    e.src   = s;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic do_clear();
    clear_signal = 1'b1;
    tick();
    clear_signal = 1'b0;
  endtask

  // Monitor: the ROB consumes the bus on every active cycle with cdb_valid high.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && cdb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bcast", 64'(cdb_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("cdb_bcast", 64'({cdb_value, cdb_tag, cdb_src}), 64'(mon_e));
      end
    end
  end

  initial begin
    src_valid = '0;
    src_value = '0;
    src_tag   = '0;
    #1 rst_in = 1'b0;
    #11;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("rst_cdb_value", 64'(cdb_value), 64'(0));
    chk("rst_cdb_tag",   64'(cdb_tag),   64'(0));
    chk("rst_cdb_src",   64'(cdb_src),   64'(0));
    #9 rst_in = 1'b1;
    tick();
    chk("rst_src_ready", 64'(src_ready), 64'(3'b111));

    // Single source: pushed in cycle 1, on the bus in cycle 3 only.
    push_src(0, 32'h0000_1234, 4'd5);
    expect_bc(32'h0000_1234, 4'd5, 2'd0);
    tick(); idle();
    chk("s1_c2_idle", 64'(cdb_valid), 64'(0));
    tick();
    chk("s1_c3_valid", 64'(cdb_valid), 64'(1));
    chk("s1_c3_tag", 64'(cdb_tag), 64'(5));
    tick();
    chk("s1_c4_done", 64'(cdb_valid), 64'(0));

    // Contention with rr_ptr = 0: tags 1, 2, 3 on consecutive cycles.
    do_clear();
    push_src(0, 32'h100, 4'd1);
    push_src(1, 32'h200, 4'd2);
    push_src(2, 32'h300, 4'd3);
    expect_bc(32'h100, 4'd1, 2'd0);
    expect_bc(32'h200, 4'd2, 2'd1);
    expect_bc(32'h300, 4'd3, 2'd2);
    tick(); idle();
    tick(); chk("s2_first_tag", 64'(cdb_tag), 64'(1));
    tick(); chk("s2_second_tag", 64'(cdb_tag), 64'(2));
    tick(); chk("s2_third_tag", 64'(cdb_tag), 64'(3));
    tick(); chk("s2_drained", 64'(cdb_valid), 64'(0));
    // rr_ptr back at 0: ALU beats load when both arrive together.
    push_src(1, 32'h700, 4'd7);
    push_src(0, 32'h600, 4'd6);
    expect_bc(32'h600, 4'd6, 2'd0);
    expect_bc(32'h700, 4'd7, 2'd1);
    tick(); idle();
    tick(); chk("s2_rr_wrap_src", 64'(cdb_src), 64'(0));
    tick(); tick();

    // Full FIFO: load pushes three back-to-back alongside ALU traffic.
    do_clear();
    expect_bc(32'hA0, 4'd1, 2'd0);
    expect_bc(32'hB0, 4'd4, 2'd1);
    expect_bc(32'hA1, 4'd2, 2'd0);
    expect_bc(32'hB1, 4'd5, 2'd1);
    expect_bc(32'hA2, 4'd3, 2'd0);
    expect_bc(32'hB2, 4'd6, 2'd1);
    push_src(0, 32'hA0, 4'd1);
    push_src(1, 32'hB0, 4'd4);
    tick();
    push_src(0, 32'hA1, 4'd2);
    push_src(1, 32'hB1, 4'd5);
    tick();
    push_src(0, 32'hA2, 4'd3);
    push_src(1, 32'hB2, 4'd6);
    chk("s3_load_full", 64'(src_ready[1]), 64'(0));
    tick();
    src_valid[0] = 1'b0;
    chk("s3_load_ready_back", 64'(src_ready[1]), 64'(1));
    chk("s3_alu_full", 64'(src_ready[0]), 64'(0));
    tick(); idle();
    tick(); tick(); tick(); tick();
    chk("s3_drained", 64'(cdb_valid), 64'(0));

    // Flush with a simultaneous push: only the already-broadcast tag 8 is seen.
    do_clear();
    push_src(0, 32'h800, 4'd8);
    push_src(1, 32'h900, 4'd9);
    push_src(2, 32'hA00, 4'd10);
    expect_bc(32'h800, 4'd8, 2'd0);
    tick();
    push_src(0, 32'h801, 4'd11);
    push_src(1, 32'h901, 4'd12);
    push_src(2, 32'hA01, 4'd13);
    tick();
    clear_signal = 1'b1;
    push_src(0, 32'h802, 4'd14);
    push_src(1, 32'h902, 4'd15);
    push_src(2, 32'hA02, 4'd0);
    chk("s4_pre_flush_tag", 64'(cdb_tag), 64'(8));
    tick();
    clear_signal = 1'b0;
    idle();
    chk("s4_flush_valid", 64'(cdb_valid), 64'(0));
    chk("s4_flush_ready", 64'(src_ready), 64'(3'b111));
    tick(); tick(); tick(); tick();
    chk("s4_no_stale", 64'(cdb_valid), 64'(0));

    // Pause: broadcast of tag 4 is frozen for three cycles, consumed once.
    push_src(0, 32'h44, 4'd4);
    expect_bc(32'h44, 4'd4, 2'd0);
    tick();
    push_src(0, 32'h66, 4'd6);
    expect_bc(32'h66, 4'd6, 2'd0);
    tick(); idle();
    rdy_in = 1'b0;
    chk("s5_c_tag", 64'({cdb_valid, cdb_tag}), 64'({1'b1, 4'd4}));
    tick();
    chk("s5_d_hold", 64'({cdb_valid, cdb_tag}), 64'({1'b1, 4'd4}));
    tick();
    chk("s5_e_hold", 64'({cdb_valid, cdb_tag}), 64'({1'b1, 4'd4}));
    tick();
    rdy_in = 1'b1;
    chk("s5_f_hold", 64'({cdb_valid, cdb_tag}), 64'({1'b1, 4'd4}));
    tick();
    chk("s5_g_next", 64'({cdb_valid, cdb_tag}), 64'({1'b1, 4'd6}));
    tick();
    chk("s5_h_idle", 64'(cdb_valid), 64'(0));

    // Asynchronous reset mid-traffic.
    push_src(0, 32'h11, 4'd1);
    push_src(1, 32'h22, 4'd2);
    tick(); idle();
    tick();
    chk("s6_pre_rst_valid", 64'(cdb_valid), 64'(1));
    #2 rst_in = 1'b0;
    #1;
    chk("s6_async_valid", 64'(cdb_valid), 64'(0));
    chk("s6_async_bus", 64'({cdb_value, cdb_tag, cdb_src}), 64'(0));
    tick(); tick();
    rst_in = 1'b1;
    tick();
    chk("s6_post_ready", 64'(src_ready), 64'(3'b111));
    tick(); tick();
    chk("s6_fifos_empty", 64'(cdb_valid), 64'(0));
    // rr_ptr is 0 after reset: ALU before branch.
    push_src(2, 32'h33, 4'd3);
    push_src(0, 32'h55, 4'd9);
    expect_bc(32'h55, 4'd9, 2'd0);
    expect_bc(32'h33, 4'd3, 2'd2);
    tick(); idle();
    tick(); chk("s6_rr_src", 64'(cdb_src), 64'(0));
    tick(); tick(); tick();

    chk("exp_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
